// File: rtl/fault_ram_pkg.sv
// Shared definitions for the fault-injection RAM: fault-type encodings and the
// location of the legacy hard-wired fault.
package fault_ram_pkg;

    typedef enum logic [1:0] {
        FLT_NONE = 2'b00,
        FLT_FLIP = 2'b01,
        FLT_SA0  = 2'b10,
        FLT_SA1  = 2'b11
    } flt_type_e;

    localparam int unsigned LEGACY_FAULT_ADDR = 100;
    localparam int unsigned LEGACY_FAULT_BIT  = 4;

    function automatic logic is_stuck(input flt_type_e t);
        return (t == FLT_SA0) || (t == FLT_SA1);
    endfunction

endpackage

// File: rtl/fault_slot_bank.sv
// Programmable fault slots; decodes write-side flip mask and read-side
// stuck-at masks plus hit flags for the current addresses.
module fault_slot_bank
    import fault_ram_pkg::*;
#(
    parameter  int unsigned DATA_W       = 8,
    parameter  int unsigned ADDR_W       = 10,
    parameter  int unsigned NUM_FAULTS   = 2,
    parameter  int unsigned LEGACY_FAULT = 1,
    localparam int unsigned SEL_W        = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int unsigned BIT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flt_cfg_en,
    input  logic [SEL_W-1:0]  flt_cfg_sel,
    input  logic [ADDR_W-1:0] flt_cfg_addr,
    input  logic [BIT_W-1:0]  flt_cfg_bit,
    input  logic [1:0]        flt_cfg_type,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] flip_mask_c,
    output logic [DATA_W-1:0] sa0_mask_c,
    output logic [DATA_W-1:0] sa1_mask_c,
    output logic              wr_hit_c,
    output logic              rd_hit_c
);

    logic [ADDR_W-1:0] addr_q [NUM_FAULTS];
    logic [ADDR_W-1:0] addr_d [NUM_FAULTS];
    logic [BIT_W-1:0]  bit_q  [NUM_FAULTS];
    logic [BIT_W-1:0]  bit_d  [NUM_FAULTS];
    flt_type_e         type_q [NUM_FAULTS];
    flt_type_e         type_d [NUM_FAULTS];
    logic [NUM_FAULTS-1:0] active_c;

    // Out-of-range slot selects are dropped.
    always_comb begin
        addr_d = addr_q;
        bit_d  = bit_q;
        type_d = type_q;
        if (flt_cfg_en && (32'(flt_cfg_sel) < NUM_FAULTS)) begin
            addr_d[flt_cfg_sel] = flt_cfg_addr;
            bit_d[flt_cfg_sel]  = flt_cfg_bit;
            type_d[flt_cfg_sel] = flt_type_e'(flt_cfg_type);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                addr_q[i] <= '0;
                bit_q[i]  <= '0;
                type_q[i] <= FLT_NONE;
            end
            if (LEGACY_FAULT != 0) begin
                addr_q[0] <= ADDR_W'(LEGACY_FAULT_ADDR);
                bit_q[0]  <= BIT_W'(LEGACY_FAULT_BIT);
                type_q[0] <= FLT_FLIP;
            end
        end else begin
            addr_q <= addr_d;
            bit_q  <= bit_d;
            type_q <= type_d;
        end
    end

    // A bit index beyond the word disables the slot.
    always_comb begin
        for (int i = 0; i < NUM_FAULTS; i++) begin
            active_c[i] = (type_q[i] != FLT_NONE) && (32'(bit_q[i]) < DATA_W);
        end
    end

    // Later slots override earlier ones on the same stuck bit.
    always_comb begin
        flip_mask_c = '0;
        sa0_mask_c  = '0;
        sa1_mask_c  = '0;
        wr_hit_c    = 1'b0;
        rd_hit_c    = 1'b0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (active_c[i] && (type_q[i] == FLT_FLIP) && (addr_q[i] == wr_addr)) begin
                flip_mask_c = flip_mask_c ^ (DATA_W'(1) << bit_q[i]);
                wr_hit_c    = 1'b1;
            end
            if (active_c[i] && is_stuck(type_q[i]) && (addr_q[i] == rd_addr)) begin
                rd_hit_c = 1'b1;
                if (type_q[i] == FLT_SA1) begin
                    sa1_mask_c = sa1_mask_c | (DATA_W'(1) << bit_q[i]);
                    sa0_mask_c = sa0_mask_c & ~(DATA_W'(1) << bit_q[i]);
                end else begin
                    sa0_mask_c = sa0_mask_c | (DATA_W'(1) << bit_q[i]);
                    sa1_mask_c = sa1_mask_c & ~(DATA_W'(1) << bit_q[i]);
                end
            end
        end
    end

endmodule

// File: rtl/fault_inject_ram.sv
// Simple-dual-port RAM with programmable flip/stuck-at fault slots, a
// 1- or 2-cycle read pipeline and a saturating fault-hit counter.
module fault_inject_ram
    import fault_ram_pkg::*;
#(
    parameter  int unsigned DATA_W       = 8,
    parameter  int unsigned ADDR_W       = 10,
    parameter  int unsigned RD_LAT       = 1,
    parameter  int unsigned NUM_FAULTS   = 2,
    parameter  int unsigned LEGACY_FAULT = 1,
    localparam int unsigned SEL_W        = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int unsigned BIT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_wrt_en,
    input  logic [ADDR_W-1:0] ram_wrt_addrs,
    input  logic [DATA_W-1:0] ram_wrt_dat,
    input  logic              ram_rd_en,
    input  logic [ADDR_W-1:0] ram_rd_addrs,
    output logic [DATA_W-1:0] ram_rd_dat,
    output logic              ram_rd_vld,
    input  logic              flt_cfg_en,
    input  logic [SEL_W-1:0]  flt_cfg_sel,
    input  logic [ADDR_W-1:0] flt_cfg_addr,
    input  logic [BIT_W-1:0]  flt_cfg_bit,
    input  logic [1:0]        flt_cfg_type,
    input  logic              flt_cnt_clr,
    output logic [15:0]       flt_hit_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 16;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] flip_mask_c, sa0_mask_c, sa1_mask_c;
    logic              wr_hit_c, rd_hit_c;

    logic [DATA_W-1:0] rd_raw_q;
    logic [DATA_W-1:0] sa0_q, sa0_d, sa1_q, sa1_d;
    logic              vld1_q, vld1_d, have_q, have_d;
    logic [DATA_W-1:0] rd_s1_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        hits_c;
    logic [CNT_W:0]    cnt_sum_c;

    fault_slot_bank #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .NUM_FAULTS   (NUM_FAULTS),
        .LEGACY_FAULT (LEGACY_FAULT)
    ) u_slots (
        .clk          (clk),
        .rst_n        (rst_n),
        .flt_cfg_en   (flt_cfg_en),
        .flt_cfg_sel  (flt_cfg_sel),
        .flt_cfg_addr (flt_cfg_addr),
        .flt_cfg_bit  (flt_cfg_bit),
        .flt_cfg_type (flt_cfg_type),
        .wr_addr      (ram_wrt_addrs),
        .rd_addr      (ram_rd_addrs),
        .flip_mask_c  (flip_mask_c),
        .sa0_mask_c   (sa0_mask_c),
        .sa1_mask_c   (sa1_mask_c),
        .wr_hit_c     (wr_hit_c),
        .rd_hit_c     (rd_hit_c)
    );

    // Array and its read register stay reset-free so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_wrt_en) begin
            mem[ram_wrt_addrs] <= ram_wrt_dat ^ flip_mask_c;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_rd_en) begin
            rd_raw_q <= mem[ram_rd_addrs];
        end
    end

    // Stuck-at masks are captured at issue alongside the raw read.
    always_comb begin
        vld1_d = ram_rd_en;
        have_d = have_q | ram_rd_en;
        sa0_d  = ram_rd_en ? sa0_mask_c : sa0_q;
        sa1_d  = ram_rd_en ? sa1_mask_c : sa1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            have_q <= 1'b0;
            sa0_q  <= '0;
            sa1_q  <= '0;
        end else begin
            vld1_q <= vld1_d;
            have_q <= have_d;
            sa0_q  <= sa0_d;
            sa1_q  <= sa1_d;
        end
    end

    // Zero until the first read after reset, since the raw register is not reset.
    assign rd_s1_c = have_q ? ((rd_raw_q & ~sa0_q) | sa1_q) : '0;

    if (RD_LAT >= 2) begin : g_lat2
        logic [DATA_W-1:0] dat2_q, dat2_d;
        logic              vld2_q, vld2_d;

        always_comb begin
            dat2_d = vld1_q ? rd_s1_c : dat2_q;
            vld2_d = vld1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat2_q <= '0;
                vld2_q <= 1'b0;
            end else begin
                dat2_q <= dat2_d;
                vld2_q <= vld2_d;
            end
        end

        assign ram_rd_dat = dat2_q;
        assign ram_rd_vld = vld2_q;
    end else begin : g_lat1
        assign ram_rd_dat = rd_s1_c;
        assign ram_rd_vld = vld1_q;
    end

    // Clear wins over that edge's hits; otherwise saturating add of up to two.
    always_comb begin
        hits_c    = 2'(ram_wrt_en & wr_hit_c) + 2'(ram_rd_en & rd_hit_c);
        cnt_sum_c = {1'b0, cnt_q} + (CNT_W+1)'(hits_c);
        if (flt_cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_sum_c[CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum_c[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign flt_hit_cnt = cnt_q;

endmodule

// File: tb/tb_fault_inject_ram.sv
// Scoreboard bench for fault_inject_ram: one instance per read latency, shared
// stimulus, expected read data and arrival cycle queued at issue.
module tb_fault_inject_ram;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned NF     = 3;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_FLIP = 2'b01;
    localparam logic [1:0] T_SA0  = 2'b10;
    localparam logic [1:0] T_SA1  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              we, re, cfg_en, clr;
    logic [ADDR_W-1:0] wa, ra, cfg_addr;
    logic [DATA_W-1:0] wd;
    logic [1:0]        cfg_sel;
    logic [2:0]        cfg_bit;
    logic [1:0]        cfg_type;

    logic [DATA_W-1:0] dat1, dat2;
    logic              vld1, vld2;
    logic [15:0]       cnt1, cnt2;

    fault_inject_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .NUM_FAULTS(NF), .LEGACY_FAULT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .ram_wrt_en(we), .ram_wrt_addrs(wa), .ram_wrt_dat(wd),
        .ram_rd_en(re), .ram_rd_addrs(ra), .ram_rd_dat(dat1), .ram_rd_vld(vld1),
        .flt_cfg_en(cfg_en), .flt_cfg_sel(cfg_sel), .flt_cfg_addr(cfg_addr),
        .flt_cfg_bit(cfg_bit), .flt_cfg_type(cfg_type),
        .flt_cnt_clr(clr), .flt_hit_cnt(cnt1)
    );

    fault_inject_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2), .NUM_FAULTS(NF), .LEGACY_FAULT(1)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .ram_wrt_en(we), .ram_wrt_addrs(wa), .ram_wrt_dat(wd),
        .ram_rd_en(re), .ram_rd_addrs(ra), .ram_rd_dat(dat2), .ram_rd_vld(vld2),
        .flt_cfg_en(cfg_en), .flt_cfg_sel(cfg_sel), .flt_cfg_addr(cfg_addr),
        .flt_cfg_bit(cfg_bit), .flt_cfg_type(cfg_type),
        .flt_cnt_clr(clr), .flt_hit_cnt(cnt2)
    );

    typedef struct {
        logic [DATA_W-1:0] dat;
        int unsigned       cyc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;
    int unsigned exp_cnt;
    logic        mon_en;

    logic [DATA_W-1:0] mem_m  [1 << ADDR_W];
    logic [ADDR_W-1:0] s_addr [NF];
    logic [2:0]        s_bit  [NF];
    logic [1:0]        s_type [NF];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en && vld1) begin
            if (q1.size() == 0) chk("l1_unexpected_vld", 1, 0);
            else begin
                e = q1.pop_front();
                chk("l1_rd_dat", dat1, e.dat);
                chk("l1_rd_cycle", cyc, e.cyc);
            end
        end
        if (rst_n && mon_en && vld2) begin
            if (q2.size() == 0) chk("l2_unexpected_vld", 1, 0);
            else begin
                e = q2.pop_front();
                chk("l2_rd_dat", dat2, e.dat);
                chk("l2_rd_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < NF; i++) begin
            s_addr[i] = '0;
            s_bit[i]  = '0;
            s_type[i] = T_NONE;
        end
        s_addr[0] = 10'd100;
        s_bit[0]  = 3'd4;
        s_type[0] = T_FLIP;
        exp_cnt   = 0;
    endtask

    // Models the coming clock edge from the inputs currently driven, then advances one cycle.
    task automatic tick();
        logic [DATA_W-1:0] rv, fm;
        int unsigned       nh;
        exp_t              e;
        nh = 0;
        if (re) begin
            logic hit;
            hit = 1'b0;
            rv  = mem_m[ra];
            for (int i = 0; i < NF; i++) begin
                if (s_addr[i] == ra && (s_type[i] == T_SA0 || s_type[i] == T_SA1)) begin
                    rv[s_bit[i]] = (s_type[i] == T_SA1);
                    hit = 1'b1;
                end
            end
            if (hit) nh++;
            e.dat = rv; e.cyc = cyc + 1; q1.push_back(e);
            e.cyc = cyc + 2;             q2.push_back(e);
        end
        if (we) begin
            logic hit;
            hit = 1'b0;
            fm  = '0;
            for (int i = 0; i < NF; i++) begin
                if (s_addr[i] == wa && s_type[i] == T_FLIP) begin
                    fm[s_bit[i]] = ~fm[s_bit[i]];
                    hit = 1'b1;
                end
            end
            if (hit) nh++;
            mem_m[wa] = wd ^ fm;
        end
        if (clr) exp_cnt = 0;
        else exp_cnt = (exp_cnt + nh > 65535) ? 65535 : exp_cnt + nh;
        if (cfg_en && 32'(cfg_sel) < NF) begin
            s_addr[cfg_sel] = cfg_addr;
            s_bit[cfg_sel]  = cfg_bit;
            s_type[cfg_sel] = cfg_type;
        end
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; re = 1'b0; cfg_en = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        re = 1'b1; ra = a;
        tick();
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [ADDR_W-1:0] a, input logic [2:0] b, input logic [1:0] t);
        cfg_en = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_bit = b; cfg_type = t;
        tick();
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_l1"}, cnt1, exp_cnt);
        chk({tag, "_l2"}, cnt2, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0; mon_en = 1'b1;
        we = 0; re = 0; cfg_en = 0; clr = 0;
        wa = '0; ra = '0; wd = '0; cfg_addr = '0; cfg_sel = '0; cfg_bit = '0; cfg_type = '0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_dat_l1", dat1, 0); chk("rst_dat_l2", dat2, 0);
        chk("rst_vld_l1", vld1, 0); chk("rst_vld_l2", vld2, 0);
        chk("rst_cnt_l1", cnt1, 0); chk("rst_cnt_l2", cnt2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Legacy slot 0 flips bit 4 of address 100 on write.
        wr(100, 8'h00); wr(99, 8'h00); rd(100); rd(99);
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(7, 8'h33);
        repeat (3) tick();
        chk("legacy_cnt", cnt1, 1);
        chk_cnt("cnt_legacy");

        // Stuck-at-1 on read path; slot select beyond NUM_FAULTS is ignored.
        cfg(1, 5, 0, T_SA1); wr(5, 8'hA4); rd(5);
        cfg(1, 5, 0, T_NONE); rd(5);
        cfg(3, 5, 1, T_SA1); rd(5);
        repeat (3) tick();
        chk_cnt("cnt_sa1");

        // Back-to-back reads.
        rd(0); rd(1); rd(2);
        repeat (3) tick();

        // Same-address read and write: read-first.
        we = 1'b1; wa = 7; wd = 8'h55; re = 1'b1; ra = 7;
        tick();
        rd(7);
        repeat (3) tick();

        // Overlapping SA0/SA1: higher slot wins; config takes effect next edge.
        cfg(0, 9, 3, T_SA0); cfg(1, 9, 3, T_SA1);
        wr(9, 8'h00); rd(9); wr(9, 8'hFF); rd(9);
        cfg(0, 9, 3, T_SA1); cfg(1, 9, 3, T_SA0); rd(9);
        cfg_en = 1'b1; cfg_sel = 1; cfg_addr = 9; cfg_bit = 3; cfg_type = T_NONE; re = 1'b1; ra = 9;
        tick();
        rd(9);
        repeat (3) tick();
        chk_cnt("cnt_overlap");

        // Two hits per cycle until the counter saturates, then clear beats hits.
        cfg(0, 200, 0, T_FLIP); cfg(1, 201, 7, T_SA1); cfg(2, 0, 0, T_NONE);
        wr(201, 8'h00);
        clr = 1'b1; tick();
        chk_cnt("cnt_clr0");
        for (int i = 0; i < 32770; i++) begin
            we = 1'b1; wa = 200; wd = 8'(i); re = 1'b1; ra = 201;
            tick();
        end
        chk("sat_cnt", cnt1, 16'hFFFF);
        chk_cnt("cnt_sat");
        we = 1'b1; wa = 200; wd = 8'h00; re = 1'b1; ra = 201;
        tick();
        chk_cnt("cnt_sat_hold");
        we = 1'b1; wa = 200; wd = 8'h00; re = 1'b1; ra = 201; clr = 1'b1;
        tick();
        chk("clr_cnt", cnt2, 0);
        chk_cnt("cnt_clr_prio");
        repeat (4) tick();

        // Reset with reads in flight.
        mon_en = 1'b0;
        re = 1'b1; ra = 0;
        @(posedge clk);
        @(negedge clk);
        ra = 1;
        @(posedge clk);
        #1 rst_n = 1'b0; re = 1'b0;
        #1;
        chk("midrst_vld_l1", vld1, 0); chk("midrst_vld_l2", vld2, 0);
        chk("midrst_dat_l1", dat1, 0); chk("midrst_dat_l2", dat2, 0);
        reset_model();
        q1.delete(); q2.delete();
        repeat (2) begin
            @(negedge clk);
            chk("inrst_vld_l1", vld1, 0); chk("inrst_vld_l2", vld2, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        chk("postrst_vld_l1", vld1, 0); chk("postrst_vld_l2", vld2, 0);
        chk("postrst_dat_l2", dat2, 0);
        chk_cnt("cnt_postrst");
        wr(100, 8'h00); rd(100);
        wr(5, 8'hA4); rd(5);
        wr(200, 8'h00); rd(200);
        repeat (4) tick();
        chk_cnt("cnt_final");
        chk("drain_l1", q1.size(), 0);
        chk("drain_l2", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
